prog_freq_divider: RTL

//  Programmable square-wave generator that produces the psi pulse train measured by the frequency

---
 rtl/prog_freq_divider_if.sv | 36 +++
 rtl/prog_freq_divider.sv | 119 +++++++++++
 2 files changed

// File: rtl/prog_freq_divider_if.sv
// Bundle of control and status signals between the frequency regulator side
// and the programmable divider. The regulator (master) drives the run enable
// and the requested half-period. The divider (slave) reports the square wave,
// the period strobe, the divisor in effect and its busy flag.
interface prog_freq_divider_if #(
   parameter int WIDTH = 8
);

   logic             en;
   logic [WIDTH-1:0] div_in;
   logic             psi;
   logic             period_done;
   logic [WIDTH-1:0] cur_div;
   logic             busy;

   // Regulator / stimulus side: drives requests, observes the generated wave
   modport master (
      output en,
      output div_in,
      input  psi,
      input  period_done,
      input  cur_div,
      input  busy
   );

   // Divider side: consumes requests, produces the wave and status
   modport slave (
      input  en,
      input  div_in,
      output psi,
      output period_done,
      output cur_div,
      output busy
   );

endinterface

// File: rtl/prog_freq_divider.sv
// Programmable square-wave generator producing the psi pulse train.
// Each psi phase (high, then low) lasts cur_div clk cycles. A new divisor is
// picked up only when a full period ends, so the wave never glitches and a
// phase is never cut short. All outputs come straight from flops.
module prog_freq_divider #(
   parameter int WIDTH   = 8,
   parameter int MIN_DIV = 1,
   parameter int RST_DIV = 'h7F
) (
   input logic                 clk,
   input logic                 rst,
   prog_freq_divider_if.slave  bus
);

   localparam logic [WIDTH-1:0] LP_MIN_DIV = WIDTH'(MIN_DIV);
   localparam logic [WIDTH-1:0] LP_RST_DIV = WIDTH'(RST_DIV);
   localparam logic [WIDTH-1:0] LP_ONE     = WIDTH'(1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HIGH = 2'd1,
      ST_LOW  = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_nextState;
   logic [WIDTH-1:0] r_cnt;
   logic [WIDTH-1:0] w_nextCnt;
   logic [WIDTH-1:0] r_curDiv;
   logic [WIDTH-1:0] w_nextCurDiv;
   logic [WIDTH-1:0] w_effDiv;
   logic             w_nextPeriodDone;
   logic             r_psi;
   logic             r_periodDone;
   logic             r_busy;

   // Clamp the requested divisor so a zero (or too small) request still
   // yields a legal phase length; only clamped values ever reach cur_div.
   always_comb begin
      w_effDiv = (bus.div_in < LP_MIN_DIV) ? LP_MIN_DIV : bus.div_in;
   end

   // Next-state logic. The counter runs 1..cur_div within each phase.
   // period_done is computed one cycle ahead so that the registered strobe
   // lines up with the last LOW cycle rather than trailing it.
   always_comb begin
      w_nextState      = r_state;
      w_nextCnt        = r_cnt;
      w_nextCurDiv     = r_curDiv;
      w_nextPeriodDone = 1'b0;

      case (r_state)
         ST_IDLE: begin
            if (bus.en) begin
               w_nextState  = ST_HIGH;
               w_nextCnt    = LP_ONE;
               w_nextCurDiv = w_effDiv;
            end
         end

         ST_HIGH: begin
            if (r_cnt == r_curDiv) begin
               w_nextState      = ST_LOW;
               w_nextCnt        = LP_ONE;
               w_nextPeriodDone = (r_curDiv == LP_ONE);
            end else begin
               w_nextCnt = r_cnt + LP_ONE;
            end
         end

         ST_LOW: begin
            if (r_cnt == r_curDiv) begin
               w_nextCurDiv = w_effDiv;
               if (bus.en) begin
                  w_nextState = ST_HIGH;
                  w_nextCnt   = LP_ONE;
               end else begin
                  w_nextState = ST_IDLE;
                  w_nextCnt   = '0;
               end
            end else begin
               w_nextCnt        = r_cnt + LP_ONE;
               w_nextPeriodDone = ((r_cnt + LP_ONE) == r_curDiv);
            end
         end

         default: begin
            w_nextState = ST_IDLE;
            w_nextCnt   = '0;
         end
      endcase
   end

   // State, counter, shadow divisor and registered outputs. Reset takes
   // priority over everything, including a period ending on the same edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= ST_IDLE;
         r_cnt        <= '0;
         r_curDiv     <= LP_RST_DIV;
         r_psi        <= 1'b0;
         r_periodDone <= 1'b0;
         r_busy       <= 1'b0;
      end else begin
         r_state      <= w_nextState;
         r_cnt        <= w_nextCnt;
         r_curDiv     <= w_nextCurDiv;
         r_psi        <= (w_nextState == ST_HIGH);
         r_periodDone <= w_nextPeriodDone;
         r_busy       <= (w_nextState != ST_IDLE);
      end
   end

   assign bus.psi         = r_psi;
   assign bus.period_done = r_periodDone;
   assign bus.cur_div     = r_curDiv;
   assign bus.busy        = r_busy;

endmodule
